vga_timing_controller: RTL and testbench
========================================

// Module: vga_timing_controller
// PURPOSE
//  Sequences the VGA raster from the pixel strobe produced by the pixel clock generator.
//  Keeps horizontal/vertical position counters and decodes hsync, vsync and videoOn from them.
//  Emits frame/blanking event pulses that schedule Game-of-Life generation updates.
//  Sits between the pixel strobe generator and the cell-grid renderer; everything runs on systemClk.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, in pixels
//  H_SYNC    96   hsync pulse width, in pixels
//  H_BP      48   horizontal back porch, in pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, in lines
//  V_SYNC    2    vsync pulse width, in lines
//  V_BP      33   vertical back porch, in lines
//  HSYNC_POL 0    asserted level of hsync (0 = active-low)
//  VSYNC_POL 0    asserted level of vsync (0 = active-low)
//  CNT_W     10   counter width; elaboration error unless H_TOTAL and V_TOTAL are both <= 2**CNT_W
// PORTS
//  systemClk   in   1      system clock; the only clock
//  rst         in   1      synchronous, active-high reset
//  pixelClk    in   1      pixel strobe, 1 systemClk wide; may be high on consecutive cycles
//  hsync       out  1      horizontal sync, registered, polarity per HSYNC_POL
//  vsync       out  1      vertical sync, registered, polarity per VSYNC_POL
//  videoOn     out  1      1 while (pixelX < H_ACTIVE) and (pixelY < V_ACTIVE)
//  pixelX      out  CNT_W  current horizontal position, 0..H_TOTAL-1
//  pixelY      out  CNT_W  current vertical position, 0..V_TOTAL-1
//  lineStart   out  1      1-cycle pulse when pixelX becomes 0
//  frameStart  out  1      1-cycle pulse when (pixelX, pixelY) becomes (0, 0)
//  vblankStart out  1      1-cycle pulse when (pixelX, pixelY) becomes (0, V_ACTIVE); the grid-update trigger
// BEHAVIOUR
//  Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
//  Reset (rst=1 at a systemClk edge, including mid-frame) loads:
//   - pixelX = H_TOTAL-1, pixelY = V_TOTAL-1
//   - videoOn = 0, hsync = !HSYNC_POL, vsync = !VSYNC_POL
//   - all pulses 0
//  So the first strobe after reset enters (0, 0) and raises frameStart. rst has priority over pixelClk.
//  Strobe cycle (pixelClk=1):
//   - pixelX <= (pixelX == H_TOTAL-1) ? 0 : pixelX+1
//   - pixelY advances only when pixelX wraps; pixelY wraps V_TOTAL-1 -> 0
//   - hsync, vsync and videoOn are registered from the NEXT counter values, so they stay aligned with pixelX/pixelY
//  Non-strobe cycle: all counters and levels hold; all pulses are 0.
//  Sync decode:
//   - hsync asserted iff H_ACTIVE+H_FP <= pixelX < H_ACTIVE+H_FP+H_SYNC (656..751)
//   - vsync asserted iff V_ACTIVE+V_FP <= pixelY < V_ACTIVE+V_FP+V_SYNC (490..491)
//  Pulses assert in the same cycle the counters take the matching value (latency 1 systemClk after the strobe edge).
//  At (0, 0), lineStart and frameStart are both 1. At (0, V_ACTIVE), lineStart and vblankStart are both 1.
//  Strobe every cycle: a strictly 1-per-cycle advance; pulses may not merge or be skipped.
//  Comparisons are done at CNT_W bits, with no overflow beyond H_TOTAL-1 / V_TOTAL-1.
// STRUCTURE
//  Package vga_timing_pkg:
//   - localparams for the 640x480@60 timing set and the H_TOTAL/V_TOTAL derivation functions
//   - typedef logic [CNT_W-1:0] vga_coord_t
//  Sub-module vga_axis_counter (params TOTAL, ACTIVE, SYNC_START, SYNC_END, POL; inputs advance, rst):
//   - wrap counter with next-value active/sync decode and a wrap output
//   - instantiated twice; the horizontal instance's wrap AND pixelClk drive the vertical advance
// TESTING
//  1 Reset, then 1 strobe -> pixelX=0, pixelY=0, frameStart=1, lineStart=1, videoOn=1, hsync=1, vsync=1.
//  2 Strobe every cycle from (0,0) -> hsync=0 at pixelX 656..751 only; lineStart at the 800th strobe with pixelY=1.
//  3 Strobe 1-in-4 cycles -> outputs hold between strobes; pulses are exactly 1 systemClk wide.
//  4 Run 800*480 strobes from (0,0) -> vblankStart=1 at (0,480) and videoOn=0; vsync=0 only for pixelY 490..491.
//  5 Full frame of 420000 strobes -> the next frameStart lands at exactly the 420000th strobe; pixelY never reaches 525.
//  6 Assert rst at (300,200) while pixelClk=1 -> next cycle shows (799,524), videoOn=0, syncs inactive, no pulses.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the VGA raster sequencer.
// Defaults describe the 640x480@60 timing set.
package vga_timing_pkg;

    localparam int CNT_W    = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam bit HSYNC_POL = 1'b0;
    localparam bit VSYNC_POL = 1'b0;

    // Period of one axis: active region plus the three blanking segments.
    function automatic int axis_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    // Half-open window test lo <= v < hi, done on plain integers so that an
    // upper bound equal to 2**CNT_W cannot overflow.
    function automatic logic in_window(int v, int lo, int hi);
        return (v >= lo) && (v < hi);
    endfunction

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    typedef logic [CNT_W-1:0] vga_coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter whose active/sync levels are
// decoded from the next count value, so they line up with the count itself.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int CNT_W      = 10,
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752,
    parameter bit POL        = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [CNT_W-1:0] count_o,
    output logic             active_o,
    output logic             sync_o,
    output logic             start_o,
    output logic             mark_o,
    output logic             wrap_o
);

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACTIVE_C = CNT_W'(ACTIVE);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             active_q;
    logic             sync_q;
    logic             start_q;
    logic             mark_q;

    // wrap_o tells the caller that the next advance returns the count to 0.
    assign wrap_o = (count_q == LAST);

    // Next position: increment, wrapping at the last position of the axis.
    always_comb begin
        count_d = wrap_o ? '0 : count_q + CNT_W'(1);
    end

    // Reset parks the counter on its last position so the first advance enters 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= LAST;
            active_q <= 1'b0;
            sync_q   <= ~POL;
            start_q  <= 1'b0;
            mark_q   <= 1'b0;
        end else if (advance) begin
            count_q  <= count_d;
            active_q <= in_window(int'(count_d), 0, ACTIVE);
            sync_q   <= in_window(int'(count_d), SYNC_START, SYNC_END) ? POL : ~POL;
            start_q  <= (count_d == '0);
            mark_q   <= (count_d == ACTIVE_C);
        end else begin
            start_q  <= 1'b0;
            mark_q   <= 1'b0;
        end
    end

    assign count_o  = count_q;
    assign active_o = active_q;
    assign sync_o   = sync_q;
    assign start_o  = start_q;
    assign mark_o   = mark_q;

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: advances pixel/line counters on each pixel strobe and
// produces sync levels, the visible-area flag and line/frame/vblank pulses.
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE_P = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP_P     = vga_timing_pkg::H_FP,
    parameter int H_SYNC_P   = vga_timing_pkg::H_SYNC,
    parameter int H_BP_P     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE_P = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP_P     = vga_timing_pkg::V_FP,
    parameter int V_SYNC_P   = vga_timing_pkg::V_SYNC,
    parameter int V_BP_P     = vga_timing_pkg::V_BP,
    parameter bit HSYNC_POL_P = vga_timing_pkg::HSYNC_POL,
    parameter bit VSYNC_POL_P = vga_timing_pkg::VSYNC_POL,
    parameter int CNT_W_P    = vga_timing_pkg::CNT_W
) (
    input  logic               systemClk,
    input  logic               rst,
    input  logic               pixelClk,
    output logic               hsync,
    output logic               vsync,
    output logic               videoOn,
    output logic [CNT_W_P-1:0] pixelX,
    output logic [CNT_W_P-1:0] pixelY,
    output logic               lineStart,
    output logic               frameStart,
    output logic               vblankStart
);

    localparam int H_TOTAL_C = axis_total(H_ACTIVE_P, H_FP_P, H_SYNC_P, H_BP_P);
    localparam int V_TOTAL_C = axis_total(V_ACTIVE_P, V_FP_P, V_SYNC_P, V_BP_P);

    // Both axes must fit in the counter width.
    generate
        if ((H_TOTAL_C > 2**CNT_W_P) || (V_TOTAL_C > 2**CNT_W_P)) begin : g_width_check
            $error("vga_timing_controller: H_TOTAL/V_TOTAL exceed 2**CNT_W");
        end
    endgenerate

    logic h_active, h_sync, h_start, h_mark, h_wrap;
    logic v_active, v_sync, v_start, v_mark, v_wrap;
    logic v_advance;

    // The line counter moves only on the strobe that wraps the pixel counter.
    assign v_advance = pixelClk & h_wrap;

    vga_axis_counter #(
        .CNT_W      (CNT_W_P),
        .TOTAL      (H_TOTAL_C),
        .ACTIVE     (H_ACTIVE_P),
        .SYNC_START (H_ACTIVE_P + H_FP_P),
        .SYNC_END   (H_ACTIVE_P + H_FP_P + H_SYNC_P),
        .POL        (HSYNC_POL_P)
    ) u_h_axis (
        .clk      (systemClk),
        .rst      (rst),
        .advance  (pixelClk),
        .count_o  (pixelX),
        .active_o (h_active),
        .sync_o   (h_sync),
        .start_o  (h_start),
        .mark_o   (h_mark),
        .wrap_o   (h_wrap)
    );

    vga_axis_counter #(
        .CNT_W      (CNT_W_P),
        .TOTAL      (V_TOTAL_C),
        .ACTIVE     (V_ACTIVE_P),
        .SYNC_START (V_ACTIVE_P + V_FP_P),
        .SYNC_END   (V_ACTIVE_P + V_FP_P + V_SYNC_P),
        .POL        (VSYNC_POL_P)
    ) u_v_axis (
        .clk      (systemClk),
        .rst      (rst),
        .advance  (v_advance),
        .count_o  (pixelY),
        .active_o (v_active),
        .sync_o   (v_sync),
        .start_o  (v_start),
        .mark_o   (v_mark),
        .wrap_o   (v_wrap)
    );

    // Every line-counter step coincides with pixelX entering 0, so the line
    // counter's own pulses already mark (0,0) and (0,V_ACTIVE).
    assign hsync       = h_sync;
    assign vsync       = v_sync;
    assign videoOn     = h_active & v_active;
    assign lineStart   = h_start;
    assign frameStart  = v_start;
    assign vblankStart = v_mark;

    logic unused_axis_bits;
    assign unused_axis_bits = &{1'b0, h_mark, v_wrap};

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: a full-size 640x480 instance and a tiny
// raster instance share one stimulus stream; a reference model predicts every
// output of both each cycle and a queue carries the predictions to the checks.
module tb_vga_timing_controller;

    logic systemClk = 1'b0;
    logic rst       = 1'b1;
    logic pixelClk  = 1'b0;

    always #5 systemClk = ~systemClk;

    // Full-size instance (defaults).
    logic       hsA, vsA, vonA, lsA, fsA, vbA;
    logic [9:0] pxA, pyA;
    // Tiny instance: 8+2+3+2 = 15 pixels, 6+2+2+3 = 13 lines, active-high hsync.
    logic       hsB, vsB, vonB, lsB, fsB, vbB;
    logic [3:0] pxB, pyB;

    vga_timing_controller dut (
        .systemClk (systemClk), .rst (rst), .pixelClk (pixelClk),
        .hsync (hsA), .vsync (vsA), .videoOn (vonA),
        .pixelX (pxA), .pixelY (pyA),
        .lineStart (lsA), .frameStart (fsA), .vblankStart (vbA)
    );

    vga_timing_controller #(
        .H_ACTIVE_P (8), .H_FP_P (2), .H_SYNC_P (3), .H_BP_P (2),
        .V_ACTIVE_P (6), .V_FP_P (2), .V_SYNC_P (2), .V_BP_P (3),
        .HSYNC_POL_P (1'b1), .VSYNC_POL_P (1'b0), .CNT_W_P (4)
    ) dut_small (
        .systemClk (systemClk), .rst (rst), .pixelClk (pixelClk),
        .hsync (hsB), .vsync (vsB), .videoOn (vonB),
        .pixelX (pxB), .pixelY (pyB),
        .lineStart (lsB), .frameStart (fsB), .vblankStart (vbB)
    );

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp;
        bit hp, vp;
    } tcfg_t;

    typedef struct {
        logic [31:0] x, y;
        logic        hs, vs, von, ls, fs, vb;
    } obs_t;

    tcfg_t cfg [2];
    int    mx  [2];
    int    my  [2];
    obs_t  cur [2];
    obs_t  sb0 [$];
    obs_t  sb1 [$];

    int compared   = 0;
    int mismatched = 0;
    int sidx       = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    // Reference raster model for instance k, one systemClk cycle.
    function automatic obs_t model_step(int k, bit s, bit r);
        tcfg_t c;
        int    ht, vt;
        c  = cfg[k];
        ht = c.ha + c.hfp + c.hs + c.hbp;
        vt = c.va + c.vfp + c.vs + c.vbp;
        if (r) begin
            mx[k] = ht - 1;
            my[k] = vt - 1;
            cur[k].von = 1'b0;
            cur[k].hs  = ~c.hp;
            cur[k].vs  = ~c.vp;
            cur[k].ls  = 1'b0;
            cur[k].fs  = 1'b0;
            cur[k].vb  = 1'b0;
        end else if (s) begin
            if (mx[k] == ht - 1) begin
                mx[k] = 0;
                my[k] = (my[k] == vt - 1) ? 0 : my[k] + 1;
            end else begin
                mx[k] = mx[k] + 1;
            end
            cur[k].ls  = (mx[k] == 0);
            cur[k].fs  = (mx[k] == 0) && (my[k] == 0);
            cur[k].vb  = (mx[k] == 0) && (my[k] == c.va);
            cur[k].von = (mx[k] < c.ha) && (my[k] < c.va);
            cur[k].hs  = (mx[k] >= c.ha + c.hfp && mx[k] < c.ha + c.hfp + c.hs) ? c.hp : ~c.hp;
            cur[k].vs  = (my[k] >= c.va + c.vfp && my[k] < c.va + c.vfp + c.vs) ? c.vp : ~c.vp;
        end else begin
            cur[k].ls = 1'b0;
            cur[k].fs = 1'b0;
            cur[k].vb = 1'b0;
        end
        cur[k].x = 32'(mx[k]);
        cur[k].y = 32'(my[k]);
        return cur[k];
    endfunction

    function automatic obs_t get_obs(int k);
        obs_t o;
        if (k == 0) begin
            o.x = 32'(pxA); o.y = 32'(pyA);
            o.hs = hsA; o.vs = vsA; o.von = vonA; o.ls = lsA; o.fs = fsA; o.vb = vbA;
        end else begin
            o.x = 32'(pxB); o.y = 32'(pyB);
            o.hs = hsB; o.vs = vsB; o.von = vonB; o.ls = lsB; o.fs = fsB; o.vb = vbB;
        end
        return o;
    endfunction

    task automatic compare_all(input int k, input obs_t e);
        obs_t o;
        o = get_obs(k);
        check($sformatf("d%0d.pixelX", k),      o.x, e.x);
        check($sformatf("d%0d.pixelY", k),      o.y, e.y);
        check($sformatf("d%0d.hsync", k),       32'(o.hs),  32'(e.hs));
        check($sformatf("d%0d.vsync", k),       32'(o.vs),  32'(e.vs));
        check($sformatf("d%0d.videoOn", k),     32'(o.von), 32'(e.von));
        check($sformatf("d%0d.lineStart", k),   32'(o.ls),  32'(e.ls));
        check($sformatf("d%0d.frameStart", k),  32'(o.fs),  32'(e.fs));
        check($sformatf("d%0d.vblankStart", k), 32'(o.vb),  32'(e.vb));
    endtask

    // Drive one cycle, queue both predictions, then check just after the edge.
    task automatic step(input bit s, input bit r);
        @(negedge systemClk);
        pixelClk = s;
        rst      = r;
        sb0.push_back(model_step(0, s, r));
        sb1.push_back(model_step(1, s, r));
        @(posedge systemClk);
        #1;
        compare_all(0, sb0.pop_front());
        compare_all(1, sb1.pop_front());
        if (s && !r) sidx++;
    endtask

    initial begin
        int hs_low, hs_first, hs_last;
        int last_fs, fs_seen, max_y;

        cfg[0] = '{ha: 640, hfp: 16, hs: 96, hbp: 48, va: 480, vfp: 10, vs: 2, vbp: 33, hp: 1'b0, vp: 1'b0};
        cfg[1] = '{ha: 8,   hfp: 2,  hs: 3,  hbp: 2,  va: 6,   vfp: 2,  vs: 2, vbp: 3,  hp: 1'b1, vp: 1'b0};

        // Reset state.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("reset.pixelX", 32'(pxA), 32'd799);
        check("reset.pixelY", 32'(pyA), 32'd524);
        check("reset.hsync",  32'(hsA), 32'd1);
        check("reset.small.hsync", 32'(hsB), 32'd0);

        // First strobe enters (0,0).
        step(1'b1, 1'b0);
        check("first.frameStart", 32'(fsA),  32'd1);
        check("first.lineStart",  32'(lsA),  32'd1);
        check("first.videoOn",    32'(vonA), 32'd1);
        check("first.hsync",      32'(hsA),  32'd1);
        check("first.vsync",      32'(vsA),  32'd1);

        // One full line, strobe every cycle.
        hs_low = 0; hs_first = -1; hs_last = -1;
        for (int i = 0; i < 800; i++) begin
            step(1'b1, 1'b0);
            if (hsA == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(pxA);
                hs_last = int'(pxA);
            end
        end
        check("line.hsync_low_count", 32'(hs_low),   32'd96);
        check("line.hsync_first_x",   32'(hs_first), 32'd656);
        check("line.hsync_last_x",    32'(hs_last),  32'd751);
        check("line.lineStart800",    32'(lsA),      32'd1);
        check("line.pixelY800",       32'(pyA),      32'd1);

        // Sparse strobes: levels hold and pulses last one cycle.
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
        end

        // Several tiny frames back to back: frame period and vblank/vsync placement.
        last_fs = -1; fs_seen = 0; max_y = 0;
        for (int i = 0; i < 700; i++) begin
            step(1'b1, 1'b0);
            if (int'(pyB) > max_y) max_y = int'(pyB);
            if (fsB) begin
                if (last_fs >= 0) check("small.frame_period", 32'(sidx - last_fs), 32'd195);
                last_fs = sidx;
                fs_seen++;
            end
            if (vbB) begin
                check("small.vblank_y",       32'(pyB),  32'd6);
                check("small.vblank_videoOn", 32'(vonB), 32'd0);
            end
            if (vsB == 1'b0) check("small.vsync_window", 32'(pyB >= 4'd8 && pyB <= 4'd9), 32'd1);
        end
        check("small.frames_seen", 32'(fs_seen >= 3), 32'd1);
        check("small.max_y",       32'(max_y),        32'd12);

        // Mid-frame reset with the strobe high: reset wins.
        step(1'b1, 1'b1);
        check("midreset.pixelX",     32'(pxA),  32'd799);
        check("midreset.pixelY",     32'(pyA),  32'd524);
        check("midreset.videoOn",    32'(vonA), 32'd0);
        check("midreset.frameStart", 32'(fsA),  32'd0);
        step(1'b1, 1'b0);
        check("after_reset.frameStart", 32'(fsA), 32'd1);
        step(1'b0, 1'b0);
        check("after_reset.pulse_width", 32'(fsA), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
